mod45_seq_checker: RTL and testbench



---
 rtl/mod45_seq_checker.sv | 103 ++++++++++
 tb/tb_mod45_seq_checker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mod45_seq_checker.sv
// Receive-side checker for the repeating 0,1,2,3,0,1,2,3,4 MOD4/MOD5 count stream.
// Hunts for frame alignment, tracks expected value/phase, and counts errors and frames.
module mod45_seq_checker #(
  parameter int ERR_CNT_W   = 8,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [2:0]             in_count,
  input  logic                   clr,
  output logic                   locked,
  output logic                   phase,
  output logic [2:0]             expected,
  output logic                   err_pulse,
  output logic                   frame_done,
  output logic [ERR_CNT_W-1:0]   err_cnt,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, LOCK = 2'd2} state_t;

  state_t     state_q, state_d;
  logic       phase_d;
  logic [2:0] exp_d;
  logic       err_d, done_d;
  logic       match, frame_end;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  function automatic logic [FRAME_CNT_W-1:0] wrap_inc(input logic [FRAME_CNT_W-1:0] v);
    return v + FRAME_CNT_W'(1);
  endfunction

  // Values 5-7 can never equal expected, which never exceeds 4.
  assign match     = (in_count == expected);
  assign frame_end = phase && (expected == 3'd4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= HUNT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase;
    exp_d   = expected;
    err_d   = 1'b0;
    done_d  = 1'b0;
    if (in_valid) begin
      if ((state_q != HUNT) && match) begin
        if (frame_end) begin
          state_d = LOCK;
          phase_d = 1'b0;
          exp_d   = 3'd0;
          done_d  = (state_q == LOCK);
        end else if (!phase && (expected == 3'd3)) begin
          phase_d = 1'b1;
          exp_d   = 3'd0;
        end else begin
          exp_d = expected + 3'd1;
        end
      end else begin
        // HUNT samples and mismatches share the realignment rule: a 4 restarts SYNC.
        err_d = (state_q == LOCK);
        if (in_count == 3'd4) begin
          state_d = SYNC;
          phase_d = 1'b0;
          exp_d   = 3'd0;
        end else begin
          state_d = HUNT;
        end
      end
    end
  end

  always_comb begin
    locked = (state_q == LOCK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase      <= 1'b0;
      expected   <= 3'd0;
      err_pulse  <= 1'b0;
      frame_done <= 1'b0;
      err_cnt    <= '0;
      frame_cnt  <= '0;
    end else begin
      phase      <= phase_d;
      expected   <= exp_d;
      err_pulse  <= err_d;
      frame_done <= done_d;
      if (clr)        err_cnt <= '0;
      else if (err_d) err_cnt <= sat_inc(err_cnt);
      if (clr)         frame_cnt <= '0;
      else if (done_d) frame_cnt <= wrap_inc(frame_cnt);
    end
  end

endmodule

// File: tb/tb_mod45_seq_checker.sv
// Directed bench for mod45_seq_checker: vector table plus hand-written corner sequences.
module tb_mod45_seq_checker;

  logic       clk, rst, in_valid, clr;
  logic [2:0] in_count;
  logic       locked, phase, err_pulse, frame_done;
  logic [2:0] expected;
  logic [1:0] err_cnt;
  logic [7:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  mod45_seq_checker #(.ERR_CNT_W(2), .FRAME_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_count(in_count), .clr(clr),
    .locked(locked), .phase(phase), .expected(expected), .err_pulse(err_pulse),
    .frame_done(frame_done), .err_cnt(err_cnt), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] c;
    logic       lk;
    logic       ph;
    logic [2:0] ex;
    logic       ep;
    logic       fd;
    logic [1:0] ec;
    logic [7:0] fc;
    logic       pe;
  } vec_t;

  vec_t tbl[$];
  vec_t last;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", n, a, e);
    end
  endtask

  task automatic add(input logic v, input logic [2:0] c, input logic lk, input logic ph,
                     input logic [2:0] ex, input logic ep, input logic fd,
                     input int ec, input int fc, input logic pe);
    vec_t r;
    r.v = v; r.c = c; r.lk = lk; r.ph = ph; r.ex = ex; r.ep = ep; r.fd = fd;
    r.ec = ec[1:0]; r.fc = fc[7:0]; r.pe = pe;
    tbl.push_back(r);
    last = r;
  endtask

  task automatic idle(input int n, input logic [2:0] g);
    vec_t r;
    r = last;
    r.v = 1'b0; r.c = g; r.ep = 1'b0; r.fd = 1'b0;
    repeat (n) tbl.push_back(r);
  endtask

  // One 0,1,2,3,0,1,2,3,4 frame; lk_run says whether the checker is already locked.
  task automatic seq9(input logic lk_run, input int ec, input int fc);
    logic [2:0] cs[9]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic       phs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] exs[9] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    for (int i = 0; i < 8; i++) add(1'b1, cs[i], lk_run, phs[i], exs[i], 1'b0, 1'b0, ec, fc, 1'b1);
    add(1'b1, 3'd4, 1'b1, 1'b0, 3'd0, 1'b0, lk_run, ec, fc + int'(lk_run), 1'b1);
  endtask

  task automatic step(input logic v, input logic [2:0] c, input logic cl);
    in_valid = v; in_count = c; clr = cl;
    @(posedge clk);
    #1;
    in_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic relock();
    logic [2:0] cs[10] = '{3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    for (int i = 0; i < 10; i++) step(1'b1, cs[i], 1'b0);
    chk("relock", locked, 1);
  endtask

  initial begin
    int m_ec;
    rst = 1'b0; in_valid = 1'b0; in_count = 3'd0; clr = 1'b0;
    #1;
    chk("rst_locked", locked, 0);    chk("rst_phase", phase, 0);
    chk("rst_expected", expected, 0); chk("rst_err_pulse", err_pulse, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_cnt", err_cnt, 0);  chk("rst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // Initial lock, then one counted frame.
    add(1, 4, 0, 0, 0, 0, 0, 0, 0, 1);
    seq9(1'b0, 0, 0);
    seq9(1'b1, 0, 0);
    idle(1, 3'd0);
    // Locked mismatch (2 where 1 expected), then relock with no further errors.
    add(1, 0, 1, 0, 1, 0, 0, 0, 1, 1);
    add(1, 2, 0, 0, 0, 1, 0, 1, 1, 0);
    idle(1, 3'd0);
    add(1, 4, 0, 0, 0, 0, 0, 1, 1, 1);
    seq9(1'b0, 1, 1);
    // Mismatching 4 where 2 is expected: error and immediate restart of SYNC.
    add(1, 0, 1, 0, 1, 0, 0, 1, 1, 1);
    add(1, 1, 1, 0, 2, 0, 0, 1, 1, 1);
    add(1, 4, 0, 0, 0, 1, 0, 2, 1, 1);
    seq9(1'b0, 2, 1);
    // Locked frame with idle gaps carrying garbage on in_count.
    add(1, 0, 1, 0, 1, 0, 0, 2, 1, 1); idle(1, 3'd7);
    add(1, 1, 1, 0, 2, 0, 0, 2, 1, 1); idle(3, 3'd5);
    add(1, 2, 1, 0, 3, 0, 0, 2, 1, 1); idle(5, 3'd6);
    add(1, 3, 1, 1, 0, 0, 0, 2, 1, 1); idle(2, 3'd3);
    add(1, 0, 1, 1, 1, 0, 0, 2, 1, 1);
    add(1, 1, 1, 1, 2, 0, 0, 2, 1, 1);
    add(1, 2, 1, 1, 3, 0, 0, 2, 1, 1); idle(4, 3'd4);
    add(1, 3, 1, 1, 4, 0, 0, 2, 1, 1); idle(1, 3'd2);
    add(1, 4, 1, 0, 0, 0, 1, 2, 2, 1);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].c, 1'b0);
      chk($sformatf("v%0d_locked", i), locked, tbl[i].lk);
      if (tbl[i].pe) begin
        chk($sformatf("v%0d_phase", i), phase, tbl[i].ph);
        chk($sformatf("v%0d_expected", i), expected, tbl[i].ex);
      end
      chk($sformatf("v%0d_err_pulse", i), err_pulse, tbl[i].ep);
      chk($sformatf("v%0d_frame_done", i), frame_done, tbl[i].fd);
      chk($sformatf("v%0d_err_cnt", i), err_cnt, tbl[i].ec);
      chk($sformatf("v%0d_frame_cnt", i), frame_cnt, tbl[i].fc);
    end

    // Saturation: five locked mismatches with relock in between.
    m_ec = 2;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 3'd1, 1'b0);
      m_ec = (m_ec == 3) ? 3 : m_ec + 1;
      chk($sformatf("sat%0d_err_pulse", k), err_pulse, 1);
      chk($sformatf("sat%0d_err_cnt", k), err_cnt, m_ec);
      chk($sformatf("sat%0d_locked", k), locked, 0);
      relock();
    end

    // Asynchronous reset between edges, mid-frame.
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    chk("pre_rst_expected", expected, 2);
    #3 rst = 1'b0;
    #1;
    chk("arst_locked", locked, 0);     chk("arst_phase", phase, 0);
    chk("arst_expected", expected, 0); chk("arst_err_pulse", err_pulse, 0);
    chk("arst_frame_done", frame_done, 0);
    chk("arst_err_cnt", err_cnt, 0);   chk("arst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // Illegal values while hunting count nothing.
    for (int v = 5; v < 8; v++) begin
      step(1'b1, 3'(v), 1'b0);
      chk($sformatf("illegal%0d_err_pulse", v), err_pulse, 0);
      chk($sformatf("illegal%0d_err_cnt", v), err_cnt, 0);
      chk($sformatf("illegal%0d_locked", v), locked, 0);
    end
    relock();

    // clr coincident with an error: counter clears, pulse still fires.
    step(1'b1, 3'd1, 1'b0);
    chk("err_before_clr", err_cnt, 1);
    relock();
    step(1'b1, 3'd2, 1'b1);
    chk("clr_err_pulse", err_pulse, 1);
    chk("clr_err_cnt", err_cnt, 0);

    // clr coincident with a frame completion.
    relock();
    begin
      logic [2:0] cs[8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
      for (int i = 0; i < 8; i++) step(1'b1, cs[i], 1'b0);
    end
    step(1'b1, 3'd4, 1'b1);
    chk("clr_frame_done", frame_done, 1);
    chk("clr_frame_cnt", frame_cnt, 0);
    step(1'b0, 3'd0, 1'b0);
    chk("pulse_drop", frame_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
